axil_cmd_master: RTL and testbench

Parametrised AXI4-Lite master that turns a simple valid/ready command stream into AXI-Lite read and write transactions and returns each result on a valid/ready response stream. It sits between a local controller (test driver, CPU-side logic) and any AXI-Lite slave such as the memory slave.

Compared with the single-command wrapper it replaces, it adds:
- configurable address and data widths, with byte strobes;
- a command FIFO, so several commands can be queued;
- independent AW/W handshakes;
- response-code reporting;
- an optional response timeout.

---
 rtl/axil_cmd_master.sv | 269 ++++++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master: queues valid/ready commands in a FIFO, runs one AXI-Lite
// read or write at a time and returns the result on a valid/ready response
// stream with the BRESP/RRESP code.
//
// Ports
//   clk, nreset      : clock and asynchronous active-low reset
//   cmd_*            : command stream (we, addr, data, strb)
//   rsp_*            : response stream (we, data, resp, timeout)
//   busy             : FIFO non-empty or transaction in flight
//   AXI_AW/W/B/AR/R* : AXI4-Lite master channels
//
// Optional build macro AXIL_MASTER_TIMEOUT_EN: aborts a response wait after
// TIMEOUT cycles with SLVERR and drains the late response in a DRAIN state.
module axil_cmd_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_we,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic                busy,
  output logic [ADDR_W-1:0]   AXI_AWADDR,
  output logic [2:0]          AXI_AWPROT,
  output logic                AXI_AWVALID,
  input  logic                AXI_AWREADY,
  output logic [DATA_W-1:0]   AXI_WDATA,
  output logic [DATA_W/8-1:0] AXI_WSTRB,
  output logic                AXI_WVALID,
  input  logic                AXI_WREADY,
  input  logic [1:0]          AXI_BRESP,
  input  logic                AXI_BVALID,
  output logic                AXI_BREADY,
  output logic [ADDR_W-1:0]   AXI_ARADDR,
  output logic [2:0]          AXI_ARPROT,
  output logic                AXI_ARVALID,
  input  logic                AXI_ARREADY,
  input  logic [DATA_W-1:0]   AXI_RDATA,
  input  logic [1:0]          AXI_RRESP,
  input  logic                AXI_RVALID,
  output logic                AXI_RREADY
);

  localparam int STRB_W = DATA_W/8;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_RESP = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam logic [2:0] S_DRAIN = 3'd4;
`endif

  logic              f_we   [DEPTH];
  logic [ADDR_W-1:0] f_addr [DEPTH];
  logic [DATA_W-1:0] f_data [DEPTH];
  logic [STRB_W-1:0] f_strb [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     count;
  logic              push, pop;

  logic [2:0]        state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;
  logic              awvalid_q, wvalid_q, arvalid_q;
  logic              bready_q, rready_q;
  logic              aw_done, w_done;
  logic              rsp_we_q, rsp_to_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [1:0]        rsp_resp_q;
  logic              aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign cmd_ready = (count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && (count != '0);

  assign aw_hs = awvalid_q && AXI_AWREADY;
  assign w_hs  = wvalid_q && AXI_WREADY;
  assign ar_hs = arvalid_q && AXI_ARREADY;
  assign b_hs  = bready_q && AXI_BVALID;
  assign r_hs  = rready_q && AXI_RVALID;

  always_ff @(posedge clk) begin
    if (push) begin
      f_we[wp]   <= cmd_we;
      f_addr[wp] <= cmd_addr;
      f_data[wp] <= cmd_data;
      f_strb[wp] <= cmd_strb;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          to_hit;

  assign to_hit = (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)              to_cnt <= '0;
    else if (state == S_RESP) to_cnt <= to_cnt + TW'(1);
    else                      to_cnt <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      rready_q   <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rsp_we_q   <= 1'b0;
      rsp_to_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_resp_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            we_q      <= f_we[rp];
            addr_q    <= f_addr[rp];
            data_q    <= f_data[rp];
            strb_q    <= f_strb[rp];
            awvalid_q <= f_we[rp];
            wvalid_q  <= f_we[rp];
            arvalid_q <= !f_we[rp];
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (we_q) begin
            if (aw_hs) begin
              awvalid_q <= 1'b0;
              aw_done   <= 1'b1;
            end
            if (w_hs) begin
              wvalid_q <= 1'b0;
              w_done   <= 1'b1;
            end
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
              bready_q <= 1'b1;
              state    <= S_RESP;
            end
          end else if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (b_hs) begin
            bready_q   <= 1'b0;
            rsp_we_q   <= 1'b1;
            rsp_data_q <= '0;
            rsp_resp_q <= AXI_BRESP;
            rsp_to_q   <= 1'b0;
            state      <= S_HOLD;
          end else if (r_hs) begin
            rready_q   <= 1'b0;
            rsp_we_q   <= 1'b0;
            rsp_data_q <= AXI_RDATA;
            rsp_resp_q <= AXI_RRESP;
            rsp_to_q   <= 1'b0;
            state      <= S_HOLD;
          end
`ifdef AXIL_MASTER_TIMEOUT_EN
          else if (to_hit) begin
            bready_q   <= 1'b0;
            rready_q   <= 1'b0;
            rsp_we_q   <= we_q;
            rsp_data_q <= '0;
            rsp_resp_q <= 2'b10;
            rsp_to_q   <= 1'b1;
            state      <= S_HOLD;
          end
`endif
        end
        S_HOLD: begin
          if (rsp_ready) begin
`ifdef AXIL_MASTER_TIMEOUT_EN
            if (rsp_to_q) begin
              // the slave still owes a B/R beat; absorb it before the next command
              bready_q <= we_q;
              rready_q <= !we_q;
              state    <= S_DRAIN;
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end
        end
`ifdef AXIL_MASTER_TIMEOUT_EN
        S_DRAIN: begin
          if (b_hs || r_hs) begin
            bready_q <= 1'b0;
            rready_q <= 1'b0;
            state    <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign AXI_AWVALID = awvalid_q;
  assign AXI_AWADDR  = awvalid_q ? addr_q : '0;
  assign AXI_AWPROT  = 3'b000;
  assign AXI_WVALID  = wvalid_q;
  assign AXI_WDATA   = wvalid_q ? data_q : '0;
  assign AXI_WSTRB   = wvalid_q ? strb_q : '0;
  assign AXI_BREADY  = bready_q;
  assign AXI_ARVALID = arvalid_q;
  assign AXI_ARADDR  = arvalid_q ? addr_q : '0;
  assign AXI_ARPROT  = 3'b000;
  assign AXI_RREADY  = rready_q;

  assign rsp_valid   = (state == S_HOLD);
  assign rsp_we      = rsp_we_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_to_q;
  assign busy        = (count != '0) || (state != S_IDLE);

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a small AXI-Lite slave model.
// Checks latency, split AW/W, FIFO full, response hold, error codes, reset.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_we;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        busy;
  logic [7:0]  AXI_AWADDR;
  logic [2:0]  AXI_AWPROT;
  logic        AXI_AWVALID;
  logic        AXI_AWREADY = 1'b0;
  logic [31:0] AXI_WDATA;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_WVALID;
  logic        AXI_WREADY = 1'b0;
  logic [1:0]  AXI_BRESP = '0;
  logic        AXI_BVALID = 1'b0;
  logic        AXI_BREADY;
  logic [7:0]  AXI_ARADDR;
  logic [2:0]  AXI_ARPROT;
  logic        AXI_ARVALID;
  logic        AXI_ARREADY = 1'b0;
  logic [31:0] AXI_RDATA = '0;
  logic [1:0]  AXI_RRESP = '0;
  logic        AXI_RVALID = 1'b0;
  logic        AXI_RREADY;

  always #5 clk = ~clk;

  axil_cmd_master #(
    .ADDR_W(8), .DATA_W(32), .DEPTH(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .nreset(nreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_we(rsp_we), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .busy(busy),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWPROT(AXI_AWPROT),
    .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB),
    .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID),
    .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARPROT(AXI_ARPROT),
    .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP),
    .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // slave model: readies driven on negedge, handshakes observed on posedge
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic        b_silent = 1'b0;
  int          aw_wait = 0, w_wait = 0, ar_wait = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
  logic [7:0]  aw_a = '0, ar_a = '0;
  logic [31:0] w_d = '0;
  logic [3:0]  w_s = '0;
  logic [31:0] mem [256];
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;

  always @(posedge clk) begin
    if (AXI_AWVALID && AXI_AWREADY) begin
      aw_got <= 1'b1; aw_a <= AXI_AWADDR; aw_cnt <= aw_cnt + 1;
    end
    if (AXI_WVALID && AXI_WREADY) begin
      w_got <= 1'b1; w_d <= AXI_WDATA; w_s <= AXI_WSTRB;
      w_cnt <= w_cnt + 1;
    end
    if (AXI_BVALID && AXI_BREADY) begin
      aw_got <= 1'b0; w_got <= 1'b0;
      mem[aw_a] <= w_d; b_cnt <= b_cnt + 1;
    end
    if (AXI_ARVALID && AXI_ARREADY) begin
      ar_got <= 1'b1; ar_a <= AXI_ARADDR; ar_cnt <= ar_cnt + 1;
    end
    if (AXI_RVALID && AXI_RREADY) ar_got <= 1'b0;
  end

  always @(negedge clk) begin
    if (AXI_AWVALID) begin
      AXI_AWREADY <= (aw_wait >= aw_delay); aw_wait <= aw_wait + 1;
    end else begin
      AXI_AWREADY <= 1'b0; aw_wait <= 0;
    end
    if (AXI_WVALID) begin
      AXI_WREADY <= (w_wait >= w_delay); w_wait <= w_wait + 1;
    end else begin
      AXI_WREADY <= 1'b0; w_wait <= 0;
    end
    if (AXI_ARVALID) begin
      AXI_ARREADY <= (ar_wait >= ar_delay); ar_wait <= ar_wait + 1;
    end else begin
      AXI_ARREADY <= 1'b0; ar_wait <= 0;
    end
    AXI_BVALID <= aw_got && w_got && !b_silent;
    AXI_BRESP  <= b_resp_cfg;
    AXI_RVALID <= ar_got;
    AXI_RDATA  <= ar_got ? mem[ar_a] : 32'h0;
    AXI_RRESP  <= r_resp_cfg;
  end

  task automatic push(input logic we, input logic [7:0] a,
                      input logic [31:0] d);
    int k = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a;
    cmd_data = d; cmd_strb = 4'hF;
    while (!cmd_ready && k < 200) begin @(negedge clk); k++; end
    check("push_ready", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input logic we,
                         input logic [31:0] d, input logic [1:0] r,
                         input logic to);
    int k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 200) begin @(negedge clk); k++; end
    check({tag, "_vld"}, rsp_valid, 1'b1);
    check(tag, {rsp_we, rsp_timeout, rsp_resp, rsp_data}, {we, to, r, d});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int k, aw_at, rv_at, split, b0, a0, w0, r0;
    logic ok;

    #1;
    check("rst_out", {AXI_AWVALID, AXI_WVALID, AXI_ARVALID, AXI_BREADY,
                      AXI_RREADY, rsp_valid, busy, cmd_ready}, 8'b0000_0001);
    check("rst_bus", {AXI_AWADDR, AXI_ARADDR, AXI_WDATA, AXI_WSTRB},
          52'h0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;

    // write then read back, slave always ready
    push(1'b1, 8'h10, 32'hDEADBEEF);
    aw_at = 0; rv_at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (AXI_AWVALID && aw_at == 0) aw_at = i;
      if (rsp_valid) begin rv_at = i; break; end
    end
    check("aw_lat", aw_at, 2);
    check("rsp_lat", rv_at, 4);
    get_rsp("wr1", 1'b1, 32'h0, 2'b00, 1'b0);
    check("slv_aw", {aw_a, w_s, w_d}, {8'h10, 4'hF, 32'hDEADBEEF});
    push(1'b0, 8'h10, 32'h0);
    get_rsp("rd1", 1'b0, 32'hDEADBEEF, 2'b00, 1'b0);

    // W accepted three cycles before AW
    aw_delay = 3; w_delay = 0;
    b0 = b_cnt; a0 = aw_cnt; w0 = w_cnt;
    push(1'b1, 8'h14, 32'h1234_5678);
    split = 0;
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge clk); k++;
      if (AXI_AWVALID && !AXI_WVALID) split++;
    end
    check("split_cyc", split, 3);
    get_rsp("wr2", 1'b1, 32'h0, 2'b00, 1'b0);
    check("split_cnt", {b_cnt - b0, aw_cnt - a0, w_cnt - w0}, {32'd1, 32'd1, 32'd1});
    aw_delay = 0;
    push(1'b0, 8'h14, 32'h0);
    get_rsp("rd2", 1'b0, 32'h1234_5678, 2'b00, 1'b0);

    // FIFO full: first command parked in HOLD, four more fill the FIFO
    push(1'b1, 8'h20, 32'd1);
    push(1'b1, 8'h24, 32'd2);
    push(1'b0, 8'h20, 32'd0);
    push(1'b1, 8'h20, 32'd3);
    push(1'b0, 8'h24, 32'd0);
    @(negedge clk);
    check("full_rdy", cmd_ready, 1'b0);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h20;
    cmd_data = '0; cmd_strb = 4'hF;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      ok &= !cmd_ready && busy;
    end
    check("full_hold", ok, 1'b1);
    get_rsp("q0", 1'b1, 32'h0, 2'b00, 1'b0);
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    check("pop_rdy", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    get_rsp("q1", 1'b1, 32'h0, 2'b00, 1'b0);
    get_rsp("q2", 1'b0, 32'd1, 2'b00, 1'b0);
    get_rsp("q3", 1'b1, 32'h0, 2'b00, 1'b0);
    get_rsp("q4", 1'b0, 32'd2, 2'b00, 1'b0);
    get_rsp("q5", 1'b0, 32'd3, 2'b00, 1'b0);

    // response held off for 10 cycles with a second read queued
    push(1'b0, 8'h24, 32'h0);
    push(1'b0, 8'h20, 32'h0);
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    r0 = ar_cnt;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      ok &= rsp_valid && (rsp_data == 32'd2) && !AXI_RREADY &&
            !AXI_ARVALID && (AXI_ARADDR == 8'h0);
    end
    check("hold_stable", ok, 1'b1);
    check("hold_no_ar", ar_cnt - r0, 0);
    get_rsp("h0", 1'b0, 32'd2, 2'b00, 1'b0);
    get_rsp("h1", 1'b0, 32'd3, 2'b00, 1'b0);

    // error codes passed through
    r_resp_cfg = 2'b10;
    push(1'b0, 8'h24, 32'h0);
    get_rsp("rerr", 1'b0, 32'd2, 2'b10, 1'b0);
    r_resp_cfg = 2'b00;
    b_resp_cfg = 2'b01;
    push(1'b1, 8'h30, 32'd5);
    get_rsp("berr", 1'b1, 32'h0, 2'b01, 1'b0);
    b_resp_cfg = 2'b00;

`ifdef AXIL_MASTER_TIMEOUT_EN
    // silent B: timeout after 16 cycles in RESP, late B drained
    b_silent = 1'b1;
    b0 = b_cnt;
    push(1'b1, 8'h50, 32'd7);
    k = 0;
    while (!AXI_BREADY && k < 50) begin @(negedge clk); k++; end
    k = 0;
    while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
    check("to_lat", k, 16);
    get_rsp("to", 1'b1, 32'h0, 2'b10, 1'b1);
    check("drain_rdy", AXI_BREADY, 1'b1);
    b_silent = 1'b0;
    k = 0;
    while (busy && k < 50) begin @(negedge clk); k++; end
    check("drain_done", {busy, AXI_BREADY}, 2'b00);
    check("drain_b", b_cnt - b0, 1);
`endif

    // reset while a write waits in ADDR
    aw_delay = 30; w_delay = 30;
    b0 = b_cnt;
    push(1'b1, 8'h40, 32'hCAFE_F00D);
    k = 0;
    while (!AXI_AWVALID && k < 10) begin @(negedge clk); k++; end
    check("mid_aw", AXI_AWVALID, 1'b1);
    nreset = 1'b0;
    #1;
    check("mid_rst", {AXI_AWVALID, AXI_WVALID, AXI_ARVALID, AXI_BREADY,
                      AXI_RREADY, rsp_valid, busy, cmd_ready}, 8'b0000_0001);
    check("mid_bus", {AXI_AWADDR, AXI_WDATA, AXI_WSTRB}, 44'h0);
    repeat (2) @(negedge clk);
    aw_delay = 0; w_delay = 0;
    nreset = 1'b1;
    push(1'b0, 8'h10, 32'h0);
    get_rsp("post_rst", 1'b0, 32'hDEADBEEF, 2'b00, 1'b0);
    check("post_b", b_cnt - b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
